// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises and edge-detects N_SRC lines, latches them as pending,
// and hands the lowest-index enabled request to the core with an ack / EOI handshake.
module interrupt_controller #(
  parameter int N_SRC       = 4,
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             bus_sel,
  input  logic             bus_we,
  input  logic [1:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  input  logic             int_ack,
  output logic             interrput,
  output logic [ID_W-1:0]  irq_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  logic [N_SRC-1:0] r_sync [SYNC_STAGES];
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_enable;
  state_t           r_state;
  logic [ID_W-1:0]  r_irq_id;
  logic             r_int;

  logic [N_SRC-1:0] w_sync_out;
  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_req;
  logic [N_SRC-1:0] w_w1c_mask;
  logic [N_SRC-1:0] w_ack_mask;
  logic [N_SRC-1:0] w_pending_next;
  logic [ID_W-1:0]  w_win_id;
  logic             w_wr;
  logic             w_unused;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_edge     = w_sync_out & ~r_prev;
  assign w_req      = r_pending & r_enable;
  assign w_wr       = bus_sel & bus_we;
  assign w_w1c_mask = (w_wr && bus_addr == 2'd1) ? bus_wdata[N_SRC-1:0] : '0;
  assign w_ack_mask = (r_state == REQ && int_ack) ? (N_SRC'(1) << r_irq_id) : '0;
  // A fresh edge overrides any clear of the same bit in the same cycle.
  assign w_pending_next = (r_pending & ~w_w1c_mask & ~w_ack_mask) | w_edge;
  assign w_unused   = ^bus_wdata[31:N_SRC];

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_req[i]) w_win_id = ID_W'(i);
    end
  end

  always_comb begin
    bus_rdata = '0;
    case (bus_addr)
      2'd0: bus_rdata[N_SRC-1:0] = r_enable;
      2'd1: bus_rdata[N_SRC-1:0] = r_pending;
      2'd2: begin
        bus_rdata[9:8]      = r_state;
        bus_rdata[ID_W-1:0] = r_irq_id;
      end
      default: bus_rdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev    <= '0;
      r_pending <= '0;
      r_enable  <= '0;
    end else begin
      r_sync[0] <= irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev    <= w_sync_out;
      r_pending <= w_pending_next;
      if (w_wr && bus_addr == 2'd0) r_enable <= bus_wdata[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_irq_id <= '0;
      r_int    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (|w_req) begin
          r_irq_id <= w_win_id;
          r_int    <= 1'b1;
          r_state  <= REQ;
        end
        REQ: if (int_ack) begin
          r_int   <= 1'b0;
          r_state <= SERVICE;
        end
        SERVICE: if (w_wr && bus_addr == 2'd3) r_state <= IDLE;
        default: begin
          r_int   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign interrput = r_int;
  assign irq_id    = r_irq_id;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (N_SRC=4, ID_W=2, SYNC_STAGES=2).
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  irq_src = '0;
  logic        bus_sel = 1'b0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        int_ack = 1'b0;
  logic        interrput;
  logic [1:0]  irq_id;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_controller #(.N_SRC(4), .ID_W(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src),
    .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .int_ack(int_ack), .interrput(interrput), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
    @(negedge clk);
    bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = '0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = addr;
    #1;
    check(tag, bus_rdata, exp);
    bus_sel = 1'b0;
  endtask

  task automatic ack;
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_int", {31'b0, interrput}, 32'h0);
    check("rst_id", {30'b0, irq_id}, 32'h0);
    rd_check("rst_enable", 2'd0, 32'h0);
    rd_check("rst_pending", 2'd1, 32'h0);
    rd_check("rst_status", 2'd2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    bus_write(2'd0, 32'hFFFF_FFFF);
    rd_check("enable_rd", 2'd0, 32'hF);
    rd_check("eoi_rd", 2'd3, 32'h0);

    // Source 2 pulse: latency and request
    irq_src = 4'b0100;
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    irq_src = 4'b0000;
    check("lat_int_low_k2", {31'b0, interrput}, 32'h0);
    rd_check("lat_pending", 2'd1, 32'h4);
    @(negedge clk);
    check("lat_int_high_k3", {31'b0, interrput}, 32'h1);
    check("lat_id", {30'b0, irq_id}, 32'h2);
    rd_check("status_req", 2'd2, 32'h102);

    ack();
    check("ack_int", {31'b0, interrput}, 32'h0);
    rd_check("ack_pending", 2'd1, 32'h0);
    rd_check("status_service", 2'd2, 32'h202);
    ack();
    rd_check("ack_outside_req", 2'd2, 32'h202);
    bus_write(2'd3, 32'h0);
    rd_check("status_idle", 2'd2, 32'h002);
    bus_write(2'd3, 32'h0);
    rd_check("eoi_outside_service", 2'd2, 32'h002);

    // Sources 3 and 1 together: 1 first, then 3
    irq_src = 4'b1010;
    cycles(2);
    irq_src = 4'b0000;
    cycles(2);
    check("pri_int", {31'b0, interrput}, 32'h1);
    check("pri_id_first", {30'b0, irq_id}, 32'h1);
    rd_check("pri_pending", 2'd1, 32'hA);
    ack();
    rd_check("pri_pending_after_ack", 2'd1, 32'h8);
    bus_write(2'd3, 32'h0);
    check("pri_int_gap", {31'b0, interrput}, 32'h0);
    @(negedge clk);
    check("pri_int_second", {31'b0, interrput}, 32'h1);
    check("pri_id_second", {30'b0, irq_id}, 32'h3);
    ack();
    bus_write(2'd3, 32'h0);
    rd_check("pri_idle", 2'd2, 32'h003);

    // Masked source 0
    bus_write(2'd0, 32'h0);
    irq_src = 4'b0001;
    cycles(2);
    irq_src = 4'b0000;
    cycles(4);
    rd_check("mask_pending", 2'd1, 32'h1);
    check("mask_int_low", {31'b0, interrput}, 32'h0);
    bus_write(2'd0, 32'h1);
    check("unmask_int_same", {31'b0, interrput}, 32'h0);
    @(negedge clk);
    check("unmask_int", {31'b0, interrput}, 32'h1);
    check("unmask_id", {30'b0, irq_id}, 32'h0);
    bus_write(2'd1, 32'h1);
    rd_check("w1c_in_req_pending", 2'd1, 32'h0);
    check("w1c_in_req_int", {31'b0, interrput}, 32'h1);
    bus_write(2'd0, 32'h0);
    check("disable_in_req_int", {31'b0, interrput}, 32'h1);
    ack();
    bus_write(2'd3, 32'h0);

    // Level held 20 cycles: exactly one request
    bus_write(2'd0, 32'hF);
    irq_src = 4'b0010;
    cycles(4);
    check("level_int", {31'b0, interrput}, 32'h1);
    check("level_id", {30'b0, irq_id}, 32'h1);
    ack();
    bus_write(2'd3, 32'h0);
    cycles(14);
    check("level_no_rereq", {31'b0, interrput}, 32'h0);
    rd_check("level_pending", 2'd1, 32'h0);
    irq_src = 4'b0000;
    cycles(4);

    // W1C colliding with a fresh edge on the same bit
    bus_write(2'd0, 32'h0);
    irq_src = 4'b0010;
    cycles(2);
    irq_src = 4'b0000;
    cycles(4);
    rd_check("coll_pre_pending", 2'd1, 32'h2);
    irq_src = 4'b0010;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    bus_write(2'd1, 32'h2);
    rd_check("coll_set_wins", 2'd1, 32'h2);
    irq_src = 4'b0000;
    bus_write(2'd1, 32'h2);
    rd_check("w1c_plain", 2'd1, 32'h0);
    cycles(3);

    // Asynchronous reset mid-request
    bus_write(2'd0, 32'hF);
    irq_src = 4'b0101;
    cycles(2);
    irq_src = 4'b0000;
    cycles(2);
    check("prerst_int", {31'b0, interrput}, 32'h1);
    rd_check("prerst_pending", 2'd1, 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_int", {31'b0, interrput}, 32'h0);
    check("arst_id", {30'b0, irq_id}, 32'h0);
    rd_check("arst_enable", 2'd0, 32'h0);
    rd_check("arst_pending", 2'd1, 32'h0);
    rd_check("arst_status", 2'd2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_write(2'd0, 32'hF);
    cycles(10);
    check("postrst_int", {31'b0, interrput}, 32'h0);
    rd_check("postrst_pending", 2'd1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Upstream feeder for the single-cycle core's `interrput` input.
- Synchronises N external interrupt sources and detects their rising edges.
- Latches detected edges as pending bits, masks them with an enable register, and presents the highest-priority request to the core.
- Holds the request until the core acknowledges it, then waits for an end-of-interrupt (EOI) write on a small memory-mapped register bus before raising the next request.

Parameters:
- N_SRC, 4: number of interrupt sources (2..8).
- ID_W, 2: width of irq_id; must satisfy 2^ID_W >= N_SRC.
- SYNC_STAGES, 2: flip-flop depth of the per-source synchroniser (>= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- irq_src  input  N_SRC  asynchronous interrupt lines, rising-edge triggered.
- bus_sel  input  1  register access strobe.
- bus_we  input  1  1 = write, 0 = read (qualified by bus_sel).
- bus_addr  input  2  register index.
- bus_wdata  input  32  write data.
- bus_rdata  output  32  read data, combinational from bus_addr.
- int_ack  input  1  core accepted the request, 1-cycle pulse.
- interrput  output  1  interrupt request to the core.
- irq_id  output  ID_W  index of the requested / in-service source.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: synchronisers, edge history, PENDING, ENABLE, irq_id = 0; interrput = 0; FSM = IDLE. Assertion mid-operation aborts any request or service immediately.
- Register map (upper bits of 32-bit words read as 0):
  - addr 0, ENABLE: R/W, bits [N_SRC-1:0].
  - addr 1, PENDING: read; a write clears bits where bus_wdata = 1 (write-1-to-clear).
  - addr 2, STATUS: read-only; {state[1:0] at bits 9:8, irq_id at bits ID_W-1:0}.
  - addr 3, EOI: write-only; any write = EOI; reads return 0.
- Edge detect:
  - sync_out = last synchroniser stage; prev register holds sync_out delayed one cycle.
  - edge = sync_out & ~prev.
  - PENDING[i] is set on the clock edge after edge[i] is high.
- Latency: irq_src[i] first sampled high at clock edge k -> PENDING[i] = 1 after edge k+SYNC_STAGES -> interrput = 1 after edge k+SYNC_STAGES+1 (default: 4 edges after the first sampling edge, counting edge k itself).
- Level held high: produces exactly one pending set. A new set requires a low phase of at least 1 synchronised cycle.
- Priority: lowest index among (PENDING & ENABLE) wins. Evaluated only in IDLE.
- FSM:
  - IDLE: if (PENDING & ENABLE) != 0, latch the winner into irq_id and go to REQ.
  - REQ: interrput = 1. On int_ack, clear PENDING[irq_id] and go to SERVICE. While in REQ, irq_id is frozen even if a higher-priority source becomes pending.
  - SERVICE: interrput = 0, irq_id held. An EOI write returns the FSM to IDLE. No nesting.
  - interrput is registered: high exactly while in REQ.
- Masking:
  - Disabled sources still latch PENDING; they raise interrput as soon as they are enabled.
  - Disabling the source that is in REQ does not withdraw the request.
- Simultaneous events:
  - A new edge and a W1C or ack-clear of the same bit in the same cycle: set wins (bit stays 1).
  - W1C of the bit currently in REQ: bit clears, request stays.
- Ignored events: int_ack outside REQ; EOI outside SERVICE.
- Bus reads have no side effects.

Test Plan:
- Reset, then ENABLE=0xF. Pulse irq_src[2] high for 3 cycles -> PENDING reads 0x4; interrput rises 4 edges after the first sampling edge; irq_id = 2.
- In REQ, pulse int_ack -> next cycle interrput = 0, PENDING = 0x0, STATUS state = SERVICE. Write EOI -> state returns to IDLE.
- irq_src[3] and irq_src[1] rise in the same cycle -> irq_id = 1 first. After ack and EOI, a second request is raised with irq_id = 3.
- ENABLE=0x0, pulse irq_src[0] -> PENDING = 0x1, interrput stays 0. Write ENABLE=0x1 -> interrput = 1 one edge later. Write PENDING=0x1 in REQ -> PENDING = 0, interrput still 1.
- Hold irq_src[1] high for 20 cycles -> only one request. Write 0x2 to PENDING in the same cycle as a fresh edge on source 1 -> PENDING[1] stays 1.
- Drop rst_n asynchronously mid-REQ (between clock edges) -> interrput = 0 and all registers = 0 immediately. With sources idle after release, no spurious request.
